// File: rtl/vend_fsm_param.sv
// vend_fsm_param: coin-accumulating vending controller with exact change,
// cancel/refund, stock tracking with sold-out lockout, restock and coin
// rejection. Every output is a register; one combinational process computes
// the next value of each register.
module vend_fsm_param #(
  parameter int PRICE      = 5,
  parameter int CREDIT_W   = 4,
  parameter int STOCK_INIT = 8,
  parameter int STOCK_W    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                one,
  input  logic                two,
  input  logic                five,
  input  logic                cancel,
  input  logic                restock,
  output logic                d,
  output logic [CREDIT_W-1:0] r,
  output logic [CREDIT_W-1:0] credit,
  output logic [STOCK_W-1:0]  stock,
  output logic                sold_out,
  output logic                coin_reject,
  output logic [1:0]          current_state
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    VEND    = 2'd1,
    REFUND  = 2'd2,
    SOLDOUT = 2'd3
  } state_t;

  localparam logic [CREDIT_W:0]  PRICE_X     = (CREDIT_W+1)'(PRICE);
  localparam logic [STOCK_W-1:0] STOCK_RST   = STOCK_W'(STOCK_INIT);
  localparam state_t             RESET_STATE = (STOCK_INIT == 0) ? SOLDOUT : ACCUM;

  state_t                state, state_nxt;
  logic [CREDIT_W-1:0]   credit_nxt, r_nxt;
  logic [STOCK_W-1:0]    stock_nxt;
  logic                  d_nxt, reject_nxt, sold_out_nxt;
  logic                  coin_any;
  logic [CREDIT_W:0]     coin_val, sum;

  // Coin decode: one > two > five, only the highest-priority coin counts.
  always_comb begin
    coin_any = one | two | five;
    if (one)       coin_val = (CREDIT_W+1)'(1);
    else if (two)  coin_val = (CREDIT_W+1)'(2);
    else if (five) coin_val = (CREDIT_W+1)'(5);
    else           coin_val = '0;
    // One extra bit so credit + largest coin cannot wrap.
    sum = {1'b0, credit} + coin_val;
  end

  // Next-state and next-output logic for every register.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a latch.
    state_nxt  = state;
    credit_nxt = credit;
    stock_nxt  = restock ? STOCK_RST : stock;
    d_nxt      = 1'b0;
    r_nxt      = '0;
    reject_nxt = 1'b0;

    unique case (state)
      ACCUM: begin
        if (cancel && (credit != '0)) begin
          // Refund outranks coins; any coin this cycle bounces.
          state_nxt  = REFUND;
          r_nxt      = credit;
          credit_nxt = '0;
          reject_nxt = coin_any;
        end else if (coin_any) begin
          if (sum >= PRICE_X) begin
            state_nxt  = VEND;
            d_nxt      = 1'b1;
            r_nxt      = CREDIT_W'(sum - PRICE_X);
            credit_nxt = '0;
            // A reload in the same cycle wins over the decrement.
            if (!restock && (stock != '0)) stock_nxt = stock - 1'b1;
          end else begin
            credit_nxt = sum[CREDIT_W-1:0];
          end
        end
      end
      VEND: begin
        reject_nxt = coin_any;
        // Exit check sees the reloaded count if restock arrived now.
        state_nxt  = (stock_nxt == '0) ? SOLDOUT : ACCUM;
      end
      REFUND: begin
        reject_nxt = coin_any;
        state_nxt  = ACCUM;
      end
      SOLDOUT: begin
        reject_nxt = coin_any;
        credit_nxt = '0;
        if (restock) state_nxt = RESET_STATE;
      end
      default: state_nxt = RESET_STATE;
    endcase

    sold_out_nxt = (state_nxt == SOLDOUT);
  end

  // Register bank with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so all registers update from the same
    // pre-edge values regardless of statement order.
    if (reset) begin
      state       <= RESET_STATE;
      credit      <= '0;
      stock       <= STOCK_RST;
      d           <= 1'b0;
      r           <= '0;
      coin_reject <= 1'b0;
      sold_out    <= (STOCK_INIT == 0);
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      stock       <= stock_nxt;
      d           <= d_nxt;
      r           <= r_nxt;
      coin_reject <= reject_nxt;
      sold_out    <= sold_out_nxt;
    end
  end

  assign current_state = state;

endmodule
